// File: rtl/div_unit_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
// Optional early termination is enabled by defining DIV_EARLY_TERM_EN.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Two's-complement magnitude of a value when it is treated as signed and negative.
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x,
                                                    input logic            neg);
    div_abs = neg ? DIV_WIDTH'(~x + DIV_WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the partial remainder.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] divisor_ext;

  assign divisor_ext = {1'b0, divisor};
  // No borrow means the difference fits and the quotient bit is 1.
  assign quot_bit    = (partial_rem >= divisor_ext);
  assign next_rem    = quot_bit ? WIDTH'(partial_rem - divisor_ext) : partial_rem[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider returning {remainder, quotient}.
// Define DIV_EARLY_TERM_EN to finish immediately when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dq_q, dq_d;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign sign_a   = signed_div_i & opdata1_i[WIDTH-1];
  assign sign_b   = signed_div_i & opdata2_i[WIDTH-1];
  assign abs_a    = sign_a ? WIDTH'(~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign abs_b    = sign_b ? WIDTH'(~opdata2_i + WIDTH'(1)) : opdata2_i;
  assign quot_fix = neg_quot_q ? WIDTH'(~dq_q + WIDTH'(1)) : dq_q;
  assign rem_fix  = neg_rem_q ? WIDTH'(~rem_q + WIDTH'(1)) : rem_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem ({rem_q, dq_q[WIDTH-1]}),
    .divisor     (dvs_q),
    .next_rem    (step_rem),
    .quot_bit    (step_qbit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dq_q       <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dq_q       <= dq_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dq_d       = dq_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
`ifdef DIV_EARLY_TERM_EN
          end else if (abs_a < abs_b) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {opdata1_i, {WIDTH{1'b0}}};
`endif
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dq_d       = abs_a;
            rem_d      = '0;
            dvs_d      = abs_b;
            neg_quot_d = sign_a ^ sign_b;
            neg_rem_d  = sign_a;
          end
        end
      end

      DIV_BYZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
          cnt_d    = '0;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          state_d  = DIV_END;
          ready_d  = DIV_RESULT_READY;
          result_d = {rem_fix, quot_fix};
        end else begin
          dq_d  = {dq_q[WIDTH-2:0], step_qbit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DIV_END: begin
        if (!start_i || annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, zero divisor, annul and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_TERM_EN
  localparam int ET_LAT = 1;
`else
  localparam int ET_LAT = 34;
`endif

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Raise a request and count edges (accept edge = 1) until ready_o is seen, bounded.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) break;
    end
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    total++; if (result_o !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divu();
    int n;
    issue(1'b0, 32'd100, 32'd7, n);
    total++; if (n !== 34) begin bad++; $display("FAIL divu_latency got=%0d want=34", n); end
    total++; if (result_o !== {32'h2, 32'hE}) begin bad++; $display("FAIL divu_result got=%h want=%h", result_o, {32'h2, 32'hE}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL divu_hold_ready got=%b want=1", ready_o); end
    total++; if (result_o !== {32'h2, 32'hE}) begin bad++; $display("FAIL divu_hold_result got=%h want=%h", result_o, {32'h2, 32'hE}); end
    drop_start();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL divu_release_ready got=%b want=0", ready_o); end
    total++; if (result_o !== 64'h0) begin bad++; $display("FAIL divu_release_result got=%h want=0", result_o); end
  endtask

  task automatic test_signed();
    int n;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, n);
    total++; if (n !== 34) begin bad++; $display("FAIL div_neg_pos_latency got=%0d want=34", n); end
    total++; if (result_o !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_neg_pos got=%h want=ffffffff_fffffffd", result_o); end
    drop_start();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, n);
    total++; if (result_o !== {32'h1, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_pos_neg got=%h want=00000001_fffffffd", result_o); end
    drop_start();
  endtask

  task automatic test_boundary();
    int n;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n);
    total++; if (result_o !== {32'h0, 32'h8000_0000}) begin bad++; $display("FAIL div_min_by_m1 got=%h want=00000000_80000000", result_o); end
    drop_start();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, n);
    total++; if (result_o !== {32'h0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divu_max_by_1 got=%h want=00000000_ffffffff", result_o); end
    drop_start();
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, n);
    total++; if (result_o !== {32'h1, 32'h1}) begin bad++; $display("FAIL divu_max_by_maxm1 got=%h want=00000001_00000001", result_o); end
    drop_start();
  endtask

  task automatic test_byzero();
    int n;
    issue(1'b1, 32'd5, 32'd0, n);
    total++; if (n !== 2) begin bad++; $display("FAIL byzero_latency got=%0d want=2", n); end
    total++; if (result_o !== 64'h0) begin bad++; $display("FAIL byzero_result got=%h want=0", result_o); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL byzero_hold got=%b want=1", ready_o); end
    drop_start();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL byzero_release got=%b want=0", ready_o); end
  endtask

  task automatic test_annul();
    int n;
    bit seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    total++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin bad++; $display("FAIL annul_on got=%b/%h want=0/0", ready_o, result_o); end
    @(negedge clk); annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL annul_no_ready got=%b want=0", seen); end
    issue(1'b0, 32'd9, 32'd3, n);
    total++; if (n !== 34) begin bad++; $display("FAIL after_annul_latency got=%0d want=34", n); end
    total++; if (result_o !== {32'h0, 32'h3}) begin bad++; $display("FAIL after_annul_result got=%h want=00000000_00000003", result_o); end
    // annul in END with start still high must return to FREE without restarting
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL annul_end got=%b want=0", ready_o); end
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL annul_end_idle got=%b want=0", ready_o); end
  endtask

  task automatic test_rst_mid();
    int n;
    bit seen;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); start_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin bad++; $display("FAIL rst_mid_on got=%b/%h want=0/0", ready_o, result_o); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_ready got=%b want=0", seen); end
    issue(1'b0, 32'd50, 32'd3, n);
    total++; if (result_o !== {32'h2, 32'h10}) begin bad++; $display("FAIL rst_then_div got=%h want=00000002_00000010", result_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin bad++; $display("FAIL rst_in_end got=%b/%h want=0/0", ready_o, result_o); end
    @(negedge clk); start_i = 1'b0; rst = 1'b0;
  endtask

  task automatic test_early_term();
    int n;
    issue(1'b0, 32'd5, 32'd9, n);
    total++; if (n !== ET_LAT) begin bad++; $display("FAIL small_latency got=%0d want=%0d", n, ET_LAT); end
    total++; if (result_o !== {32'h5, 32'h0}) begin bad++; $display("FAIL small_result got=%h want=00000005_00000000", result_o); end
    drop_start();
    issue(1'b1, 32'hFFFF_FFFD, 32'd7, n);
    total++; if (n !== ET_LAT) begin bad++; $display("FAIL small_signed_latency got=%0d want=%0d", n, ET_LAT); end
    total++; if (result_o !== {32'hFFFF_FFFD, 32'h0}) begin bad++; $display("FAIL small_signed_result got=%h want=fffffffd_00000000", result_o); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_boundary();
    test_byzero();
    test_annul();
    test_rst_mid();
    test_early_term();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
